// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
// Shared types and constants for the SHA3 result path.
//   sha3_mode_e     : digest flavour selected by the 2-bit mode input
//   writer_state_e  : states of the digest writer FSM
//   LANE_W          : Keccak lane width in bits
//   LANES_224..512  : number of 64-bit lanes pushed per digest flavour
//   lane_byteswap() : reverses the byte order of one lane
// ---------------------------------------------------------------------------
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'b00,
    SHA3_256 = 2'b01,
    SHA3_384 = 2'b10,
    SHA3_512 = 2'b11
  } sha3_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } writer_state_e;

  localparam int LANE_W    = 64;
  localparam int LANES_224 = 4;
  localparam int LANES_256 = 4;
  localparam int LANES_384 = 6;
  localparam int LANES_512 = 8;

  // Byte 0 <-> byte 7, byte 1 <-> byte 6, ... turns a Keccak little-endian
  // lane into the big-endian order used when printing a digest in hex.
  function automatic logic [LANE_W-1:0] lane_byteswap(input logic [LANE_W-1:0] lane);
    logic [LANE_W-1:0] swapped;
    swapped = '0;
    for (int b = 0; b < LANE_W / 8; b++) begin
      swapped[8*b +: 8] = lane[LANE_W - 8*(b+1) +: 8];
    end
    return swapped;
  endfunction

endpackage

// File: rtl/sha3_digest_writer.sv
// ---------------------------------------------------------------------------
// sha3_digest_writer
// Producer side of the SHA3 result FIFO. Captures one finished digest from
// the Keccak core, then pushes it lane by lane (lane 0 first) into the result
// FIFO, stalling whenever the FIFO reports full. A one-cycle done pulse marks
// the cycle after the final lane has been written.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous, active-low reset
//   digest_in      finished digest, lane k = digest_in[64k+63:64k]
//   mode           00=SHA3-224 01=SHA3-256 10=SHA3-384 11=SHA3-512
//   digest_valid   digest_in/mode valid
//   digest_ready   writer can accept a digest (registered, 1 only in IDLE)
//   fifo_full      result FIFO full flag
//   fifo_wr_en     FIFO write strobe
//   fifo_data      FIFO write data (0 outside WRITE)
//   busy           serialisation in progress (WRITE or DONE)
//   done           one-cycle pulse after the last lane is written
//   lanes_written  lanes pushed for the current digest
//
// Build option: define SHA3_LANE_BYTESWAP_EN to byte-reverse every lane on
// the fifo_data path. Without it lanes leave in Keccak little-endian order.
// ---------------------------------------------------------------------------
module sha3_digest_writer
  import sha3_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DIGEST_W  = 512,
  parameter int MAX_LANES = 8,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic [1:0]          mode,
  input  logic                digest_valid,
  output logic                digest_ready,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [WIDTH-1:0]    fifo_data,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    lanes_written
);

  localparam int IDX_W = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;

  writer_state_e                       state_reg;
  logic [CNT_W-1:0]                    n_lanes_reg;
  logic [MAX_LANES-1:0][WIDTH-1:0]     lane_buf_reg;
  logic [MAX_LANES-1:0][WIDTH-1:0]     capture_lanes;
  logic [WIDTH-1:0]                    sel_lane;
  logic                                capture;
  logic [CNT_W-1:0]                    mode_lanes;

  // Slice the incoming digest into lanes. For SHA3-224 the digest is only
  // 224 bits, so the upper half of lane 3 is junk and is zeroed at capture.
  generate
    for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
      if (gi == 3) begin : g_trunc
        assign capture_lanes[gi] = (mode == SHA3_224)
          ? {{(WIDTH/2){1'b0}}, digest_in[gi*WIDTH +: WIDTH/2]}
          : digest_in[gi*WIDTH +: WIDTH];
      end else begin : g_full
        assign capture_lanes[gi] = digest_in[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  always_comb begin
    mode_lanes = CNT_W'(LANES_512);
    case (mode)
      SHA3_224: mode_lanes = CNT_W'(LANES_224);
      SHA3_256: mode_lanes = CNT_W'(LANES_256);
      SHA3_384: mode_lanes = CNT_W'(LANES_384);
      default:  mode_lanes = CNT_W'(LANES_512);
    endcase
  end

  assign capture = (state_reg == IDLE) && digest_valid && digest_ready;

  // Writes are gated directly by fifo_full so a full FIFO stalls the lane
  // in the same cycle, without a registered round trip.
  assign fifo_wr_en = (state_reg == WRITE) && !fifo_full;

  assign sel_lane = lane_buf_reg[lanes_written[IDX_W-1:0]];

`ifdef SHA3_LANE_BYTESWAP_EN
  assign fifo_data = (state_reg == WRITE) ? WIDTH'(lane_byteswap(LANE_W'(sel_lane))) : '0;
`else
  assign fifo_data = (state_reg == WRITE) ? sel_lane : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_buf_reg <= '0;
    end else if (capture) begin
      lane_buf_reg <= capture_lanes;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      n_lanes_reg   <= '0;
      digest_ready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lanes_written <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture) begin
            n_lanes_reg   <= mode_lanes;
            lanes_written <= '0;
            digest_ready  <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= WRITE;
          end else begin
            // Ready rises on the first clock after reset is released.
            digest_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (fifo_wr_en) begin
            lanes_written <= lanes_written + CNT_W'(1);
            if (lanes_written == n_lanes_reg - CNT_W'(1)) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          digest_ready <= 1'b1;
          state_reg    <= IDLE;
        end
        default: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          digest_ready <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_digest_writer.sv
module tb_sha3_digest_writer;

  logic         clk;
  logic         reset_n;
  logic [511:0] digest_in;
  logic [1:0]   mode;
  logic         digest_valid;
  logic         digest_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [63:0]  fifo_data;
  logic         busy;
  logic         done;
  logic [3:0]   lanes_written;

  sha3_digest_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .digest_in     (digest_in),
    .mode          (mode),
    .digest_valid  (digest_valid),
    .digest_ready  (digest_ready),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data     (fifo_data),
    .busy          (busy),
    .done          (done),
    .lanes_written (lanes_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_done;
    logic [63:0] data;
    int          count;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          accept_cyc = 0;
  bit          first_pending = 0;
  bit          mon_en = 0;
  int          wr_count = 0;
  int          done_count = 0;
  logic [63:0] first_data = '0;
  int          full_mode = 0;   // 0 never, 1 random, 2 toggle, 3 depth-4 fifo model
  int          occ = 0;
  int          reader_hold = 0;
  int          lanes_tbl[4] = '{4, 4, 6, 8};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference lane transform: byte reversal when the option is built in.
  function automatic logic [63:0] model_lane(input logic [63:0] l);
    logic [7:0] bytes[8];
    logic [63:0] r;
    for (int b = 0; b < 8; b++) bytes[b] = l[8*b +: 8];
    r = l;
`ifdef SHA3_LANE_BYTESWAP_EN
    for (int b = 0; b < 8; b++) r[8*b +: 8] = bytes[7-b];
`endif
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO full driver: the write seen before an edge is counted after it.
  initial begin
    bit wr_pend;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      wr_pend = fifo_wr_en;
      @(posedge clk);
      #1;
      case (full_mode)
        1: fifo_full = ($urandom_range(0, 99) < 40);
        2: fifo_full = ~fifo_full;
        3: begin
          if (wr_pend) occ++;
          if (reader_hold > 0) reader_hold--;
          else if (occ > 0) occ--;
          fifo_full = (occ >= 4);
        end
        default: fifo_full = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  initial begin
    bit   prev_done = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && mon_en) begin
        if (fifo_wr_en) begin
          chk("wr_while_full", {63'b0, fifo_full}, 64'd0);
          chk("busy_during_write", {63'b0, busy}, 64'd1);
          if (sb.size() == 0 || sb[0].is_done) begin
            chk("unexpected_write", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("lane_data", fifo_data, e.data);
          end
          if (first_pending) begin
            first_data = fifo_data;
            if (full_mode == 0) chk("first_write_latency", 64'(cyc), 64'(accept_cyc + 1));
            first_pending = 0;
          end
          wr_count++;
        end
        if (done) begin
          done_count++;
          if (sb.size() == 0 || !sb[0].is_done) begin
            chk("early_or_extra_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("lanes_written_at_done", 64'(lanes_written), 64'(e.count));
            chk("busy_at_done", {63'b0, busy}, 64'd1);
          end
        end
        if (prev_done) begin
          chk("done_single_pulse", {63'b0, done}, 64'd0);
          chk("ready_after_done", {63'b0, digest_ready}, 64'd1);
          chk("idle_not_busy", {63'b0, busy}, 64'd0);
        end
        prev_done = done;
      end else begin
        prev_done = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [511:0] d);
    bit ok;
    int n;
    logic [63:0] l;
    exp_t e;
    @(negedge clk);
    digest_valid = 1'b1;
    mode = m;
    digest_in = d;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (digest_ready) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      n = lanes_tbl[m];
      for (int k = 0; k < n; k++) begin
        l = d[64*k +: 64];
        if (m == 2'b00 && k == 3) l[63:32] = '0;
        e.is_done = 0; e.data = model_lane(l); e.count = 0;
        sb.push_back(e);
      end
      e.is_done = 1; e.data = '0; e.count = n;
      sb.push_back(e);
      accept_cyc = cyc;
      first_pending = 1;
    end
    @(posedge clk);
    #1;
    digest_valid = 1'b0;
    digest_in = {16{$urandom()}};
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) ok = 1;
    end
    if (!ok) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [511:0] d);
    int d0;
    d0 = done_count;
    issue(m, d);
    wait_done();
    @(negedge clk);
    #2;
    chk("done_count_per_digest", 64'(done_count - d0), 64'd1);
  endtask

  function automatic logic [511:0] counting_digest(input int base);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'(base + k);
    return d;
  endfunction

  initial begin
    logic [511:0] d;
    logic [63:0]  swap_exp;
    int           w0;
    bit           ok;
    reset_n = 1'b0;
    digest_in = '0;
    mode = 2'b00;
    digest_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_digest_ready", {63'b0, digest_ready}, 64'd0);
    chk("rst_fifo_wr_en", {63'b0, fifo_wr_en}, 64'd0);
    chk("rst_fifo_data", fifo_data, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_lanes_written", 64'(lanes_written), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {63'b0, digest_ready}, 64'd1);
    mon_en = 1;

    // SHA3-256 with lanes 1..4, no back-pressure.
    full_mode = 0;
    send(2'b01, counting_digest(1));

    // SHA3-224: upper half of lane 3 must be dropped.
    d = counting_digest(16);
    d[3*64 +: 64] = 64'hFFFFFFFF_AAAAAAAA;
    send(2'b00, d);

    // Byte order of the output path.
    d = counting_digest(32);
    d[63:0] = 64'h01020304_05060708;
`ifdef SHA3_LANE_BYTESWAP_EN
    swap_exp = 64'h08070605_04030201;
`else
    swap_exp = 64'h01020304_05060708;
`endif
    send(2'b01, d);
    chk("lane0_byte_order", first_data, swap_exp);

    // SHA3-512 into a depth-4 FIFO whose reader is stalled for a while.
    full_mode = 3;
    occ = 0;
    reader_hold = 12;
    send(2'b11, counting_digest(100));

    // SHA3-384 with fifo_full toggling every cycle.
    full_mode = 2;
    send(2'b10, counting_digest(200));

    // Random digests and modes with random back-pressure.
    full_mode = 1;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
      send(2'($urandom_range(0, 3)), d);
    end

    // Reset in the middle of a SHA3-512 serialisation.
    full_mode = 0;
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    w0 = wr_count;
    issue(2'b11, counting_digest(300));
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (wr_count - w0 >= 2) ok = 1;
    end
    chk("mid_write_reached", {63'b0, ok}, 64'd1);
    reset_n = 1'b0;
    mon_en = 0;
    #1;
    chk("async_rst_fifo_wr_en", {63'b0, fifo_wr_en}, 64'd0);
    chk("async_rst_fifo_data", fifo_data, 64'd0);
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_done", {63'b0, done}, 64'd0);
    chk("async_rst_lanes_written", 64'(lanes_written), 64'd0);
    chk("async_rst_digest_ready", {63'b0, digest_ready}, 64'd0);
    sb.delete();
    first_pending = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_ready", {63'b0, digest_ready}, 64'd1);
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    mon_en = 1;
    send(2'b01, counting_digest(400));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // One line per DUT write, for following the lane stream.
  initial forever begin
    @(negedge clk);
    if (reset_n && fifo_wr_en)
      $display("t=%0t write lane %0d data=0x%016h", $time, lanes_written, fifo_data);
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha3_digest_writer.md
Name: sha3_digest_writer

Overview:
- Producer side of the SHA3 result FIFO.
- Accepts one finished digest (up to 512 bits) from the Keccak core via a valid/ready handshake.
- Serialises it into 64-bit lanes and pushes them into the result FIFO, honouring the FIFO full flag.
- Raises a one-cycle done pulse when the last lane has been written.

Parameters:
- WIDTH, 64, lane/FIFO data width in bits.
- DIGEST_W, 512, maximum digest width; must equal WIDTH*MAX_LANES.
- MAX_LANES, 8, maximum lanes per digest.
- CNT_W, 4, lane counter width; must hold MAX_LANES.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- digest_in  input  DIGEST_W  finished digest; lane k is digest_in[64k+63:64k].
- mode  input  2  00=SHA3-224, 01=SHA3-256, 10=SHA3-384, 11=SHA3-512; sampled with digest_valid.
- digest_valid  input  1  digest_in/mode valid.
- digest_ready  output  1  block can accept a digest.
- fifo_full  input  1  result FIFO is_full.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_data  output  WIDTH  FIFO write data.
- busy  output  1  digest capture or serialisation in progress.
- done  output  1  one-cycle pulse after the last lane is written.
- lanes_written  output  CNT_W  lanes pushed for the current digest.

Behaviour:
- Reset values: digest_ready=0 during reset, then 1 in IDLE. fifo_wr_en=0, fifo_data=0, busy=0, done=0, lanes_written=0. State=IDLE. Lane buffer cleared.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - digest_ready=1.
  - On digest_valid&&digest_ready: register digest_in into the lane buffer and latch the lane count.
  - Lane counts: mode 00 -> 4 lanes, lane 3 bits[63:32] forced to 0. mode 01 -> 4. mode 10 -> 6. mode 11 -> 8.
  - Clear lanes_written, go to WRITE.
- WRITE:
  - digest_ready=0, busy=1.
  - fifo_wr_en = !fifo_full. This is combinational from registered state and the fifo_full input.
  - fifo_data = buffer lane[lanes_written]. Combinational mux; 0 outside WRITE.
  - Each cycle with fifo_wr_en=1: lanes_written increments.
  - On the write where lanes_written == n_lanes-1: go to DONE.
  - fifo_full=1 stalls with no write and no counter change. Stall length is unbounded.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - lanes_written holds the final count (4/6/8).
  - Next cycle: IDLE.
- Latency:
  - Capture edge to first fifo_wr_en: 1 cycle.
  - With no back-pressure, n_lanes consecutive write cycles, then done on the following cycle.
  - A new digest is accepted 2 cycles after the last lane.
- Lane order is strictly ascending: lane 0 first.
- digest_valid while not in IDLE is ignored (digest_ready=0). The source must hold digest_in/mode until accepted.
- Works with any FIFO depth ≥1. With DEPTH=4 and SHA3-512, back-pressure is exercised by design.
- fifo_full toggling every cycle: writes occur only on non-full cycles, with no lane skipped or duplicated.
- Reset asserted mid-WRITE: immediately return to IDLE and clear all outputs. Lanes already pushed remain the FIFO's responsibility; the FIFO shares reset_n.
- mode is ignored outside the capture cycle.

Optional Feature:
- Macro SHA3_LANE_BYTESWAP_EN.
- Defined: each lane is byte-reversed (byte 0 <-> byte 7, ...) on the fifo_data path, giving a big-endian hex-ordered stream. For SHA3-224 the zeroed upper half becomes the low 32 bits after the swap.
- Undefined: lanes are passed unmodified (Keccak little-endian). No extra logic or ports either way.

Decomposition:
- Package sha3_pkg holds:
  - typedef enum sha3_mode_e {SHA3_224, SHA3_256, SHA3_384, SHA3_512}.
  - typedef enum writer_state_e {IDLE, WRITE, DONE}.
  - Constants LANE_W=64 and LANES_224/256/384/512 = 4/4/6/8.
  - Function lane_byteswap().
- No sub-module: the mux, counter and FSM stay in a single module.

Test Plan:
- SHA3-256, digest lanes 0x..01..04, fifo_full=0 -> 4 consecutive writes 1..4 starting 1 cycle after capture; done pulses once; lanes_written=4.
- SHA3-224, lane3=0xFFFFFFFF_AAAAAAAA -> 4th write data 0x00000000_AAAAAAAA; done after 4 writes.
- SHA3-512 into DEPTH=4 FIFO with reader stalled 10 cycles -> exactly 4 writes, then fifo_wr_en=0 while full. Resume reads -> lanes 5..8 follow in order; total 8 writes; done once.
- fifo_full toggling 1/0 each cycle with SHA3-384 -> 6 writes only on non-full cycles, data order 0..5 with no duplicates.
- reset_n low after 2 writes of SHA3-512 -> all outputs 0 asynchronously. After release: IDLE, digest_ready=1, and a new SHA3-256 digest writes 4 lanes cleanly.
- With SHA3_LANE_BYTESWAP_EN, lane 0x0102030405060708 -> fifo_data 0x0807060504030201. Without it -> unchanged.
